spi_mem_responder: RTL and testbench

- SPI target (responder) that terminates the frames issued by the processor-side SPI master of the external memory controller.
- Decodes command, address and data. Serves reads and writes from an internal word array.
- Used as the on-chip/testbench stand-in for external SPI memory, and as a memory-mapped SPI peripheral.
- Oversamples the SPI lines in the CLK domain. No logic is clocked by spi_clk.

---
 rtl/spi_mem_responder_pkg.sv | 26 ++
 rtl/spi_mem_responder_sync_edge.sv | 36 +++
 rtl/spi_mem_responder.sv | 249 ++++++++++++++++++++++++
 tb/tb_spi_mem_responder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_responder_pkg.sv
// spi_mem_responder_pkg
//   Shared constants and types for the SPI memory responder:
//   command opcodes, frame field widths, bit-counter width and the
//   frame-decoder state encoding.
package spi_mem_responder_pkg;

   localparam logic [7:0] CMD_READ  = 8'h03;
   localparam logic [7:0] CMD_WRITE = 8'h02;

   localparam int CMD_W  = 8;
   localparam int ADDR_W = 24;
   localparam int DATA_W = 32;

   // Counter must reach DATA_W (32) to mark "read data fully shifted".
   localparam int CNT_W = 6;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      ADDR,
      RDATA,
      WDATA,
      IGNORE
   } state_t;

endpackage

// File: rtl/spi_mem_responder_sync_edge.sv
// spi_sync_edge
//   Two-flop synchroniser for an asynchronous input followed by a third
//   register used to detect rising and falling edges in the clk domain.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   din    asynchronous input line
//   rise   one-cycle pulse after a synchronised 0->1 transition
//   fall   one-cycle pulse after a synchronised 1->0 transition
// Parameter RESET_VAL is the idle level of the line, so leaving reset
// never produces a spurious edge.
module spi_sync_edge #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise,
   output logic fall
);

   // pipe[1:0] is the synchroniser, pipe[2] holds the previous value.
   logic [2:0] pipe_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pipe_reg <= {3{RESET_VAL}};
      end else begin
         pipe_reg <= {pipe_reg[1:0], din};
      end
   end

   assign rise = pipe_reg[1] & ~pipe_reg[2];
   assign fall = ~pipe_reg[1] & pipe_reg[2];

endmodule

// File: rtl/spi_mem_responder.sv
// spi_mem_responder
//   SPI mode-0 target that decodes cmd[7:0] / addr[23:0] / data[31:0]
//   frames (MSB first) and serves READ (0x03) and WRITE (0x02) from an
//   internal DEPTH x 32 word array. All SPI lines are oversampled in the
//   CLK domain; CLK must run at least 8x spi_clk.
// Ports:
//   CLK, reset_n        system clock, asynchronous active-low reset
//   spi_clk/mosi/cs_n   SPI inputs from the master
//   spi_miso, spi_miso_oe  serial read data and its drive enable
//   busy                high while a frame is open
//   wr_strobe/rd_strobe one-CLK pulses on array write commit / read fetch
//   bd_we/addr/wdata    backdoor write port (CLK domain)
//   bd_rdata            backdoor read data, one-cycle latency
module spi_mem_responder
   import spi_mem_responder_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          CLK,
   input  logic          reset_n,
   input  logic          spi_clk,
   input  logic          spi_mosi,
   input  logic          spi_cs_n,
   output logic          spi_miso,
   output logic          spi_miso_oe,
   output logic          busy,
   output logic          wr_strobe,
   output logic          rd_strobe,
   input  logic          bd_we,
   input  logic [AW-1:0] bd_addr,
   input  logic [31:0]   bd_wdata,
   output logic [31:0]   bd_rdata
);

   localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] DATA_END  = CNT_W'(DATA_W);

   // ---------------------------------------------------------------
   // Input synchronisation
   // ---------------------------------------------------------------
   logic sclk_rise;
   logic sclk_fall;
   logic cs_rise;
   logic cs_fall;
   logic [1:0] mosi_sync_reg;
   logic mosi_s;

   spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
      .clk   (CLK),
      .rst_n (reset_n),
      .din   (spi_clk),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
      .clk   (CLK),
      .rst_n (reset_n),
      .din   (spi_cs_n),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   // Same two-stage delay as spi_clk, so mosi_s is aligned with sclk_rise.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         mosi_sync_reg <= 2'b00;
      end else begin
         mosi_sync_reg <= {mosi_sync_reg[0], spi_mosi};
      end
   end

   assign mosi_s = mosi_sync_reg[1];

   // ---------------------------------------------------------------
   // Frame decoder state
   // ---------------------------------------------------------------
   state_t           state_reg;
   logic [CNT_W-1:0] bit_cnt_reg;
   // Holds the 31 most recent bits; with the current mosi bit it forms
   // the full 32-bit data word (or the low bits of cmd/addr).
   logic [30:0]      shift_reg;
   // Remaining read bits after the MSB has been put on miso.
   logic [30:0]      tx_reg;
   logic [AW-1:0]    idx_reg;
   logic             is_read_reg;
   logic             fetch_reg;

   logic [31:0]      mem [DEPTH];

   logic             spi_we;
   logic [31:0]      spi_wdata;

   // The write commits on the same CLK that the 32nd data bit is seen.
   always_comb begin
      spi_we    = 1'b0;
      spi_wdata = {shift_reg, mosi_s};
      if (state_reg == WDATA && sclk_rise && !cs_rise && !cs_fall &&
          bit_cnt_reg == DATA_LAST) begin
         spi_we = 1'b1;
      end
   end

   // Two write ports; the SPI write is placed last so it wins a
   // same-index collision with the backdoor.
   always_ff @(posedge CLK) begin
      if (bd_we) begin
         mem[bd_addr] <= bd_wdata;
      end
      if (spi_we) begin
         mem[idx_reg] <= spi_wdata;
      end
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= IDLE;
         bit_cnt_reg <= '0;
         shift_reg   <= '0;
         tx_reg      <= '0;
         idx_reg     <= '0;
         is_read_reg <= 1'b0;
         fetch_reg   <= 1'b0;
         spi_miso    <= 1'b0;
         spi_miso_oe <= 1'b0;
         busy        <= 1'b0;
         wr_strobe   <= 1'b0;
         rd_strobe   <= 1'b0;
         bd_rdata    <= '0;
      end else begin
         wr_strobe <= spi_we;
         rd_strobe <= 1'b0;
         // Reads the pre-write contents, so a same-cycle SPI write to
         // this index is not yet visible.
         bd_rdata  <= mem[bd_addr];

         if (cs_rise) begin
            state_reg   <= IDLE;
            busy        <= 1'b0;
            spi_miso_oe <= 1'b0;
            spi_miso    <= 1'b0;
            bit_cnt_reg <= '0;
            fetch_reg   <= 1'b0;
         end else if (cs_fall) begin
            // A fall while a frame is already open aborts it and restarts.
            state_reg   <= CMD;
            busy        <= 1'b1;
            spi_miso_oe <= 1'b0;
            spi_miso    <= 1'b0;
            bit_cnt_reg <= '0;
            fetch_reg   <= 1'b0;
         end else begin
            case (state_reg)
               IDLE: begin
               end

               CMD: begin
                  if (sclk_rise) begin
                     shift_reg <= {shift_reg[29:0], mosi_s};
                     if (bit_cnt_reg == CMD_LAST) begin
                        bit_cnt_reg <= '0;
                        if ({shift_reg[6:0], mosi_s} == CMD_READ) begin
                           is_read_reg <= 1'b1;
                           state_reg   <= ADDR;
                        end else if ({shift_reg[6:0], mosi_s} == CMD_WRITE) begin
                           is_read_reg <= 1'b0;
                           state_reg   <= ADDR;
                        end else begin
                           state_reg <= IGNORE;
                        end
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                     end
                  end
               end

               ADDR: begin
                  if (sclk_rise) begin
                     shift_reg <= {shift_reg[29:0], mosi_s};
                     if (bit_cnt_reg == ADDR_LAST) begin
                        bit_cnt_reg <= '0;
                        // Address bit k sits in shift_reg[k-1]; word index
                        // is addr[AW+1:2], upper bits wrap away.
                        idx_reg <= shift_reg[AW:1];
                        if (is_read_reg) begin
                           state_reg <= RDATA;
                           fetch_reg <= 1'b1;
                        end else begin
                           state_reg <= WDATA;
                        end
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                     end
                  end
               end

               RDATA: begin
                  if (fetch_reg) begin
                     fetch_reg   <= 1'b0;
                     tx_reg      <= mem[idx_reg][30:0];
                     spi_miso    <= mem[idx_reg][31];
                     spi_miso_oe <= 1'b1;
                     rd_strobe   <= 1'b1;
                  end else if (sclk_rise) begin
                     // Counts master sampling edges of the data phase.
                     if (bit_cnt_reg != DATA_END) begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                     end
                  end else if (sclk_fall) begin
                     // The fall trailing the last address bit (count 0)
                     // must not shift: the MSB is already on the line.
                     if (bit_cnt_reg == DATA_END) begin
                        spi_miso <= 1'b0;
                     end else if (bit_cnt_reg != '0) begin
                        spi_miso <= tx_reg[30];
                        tx_reg   <= {tx_reg[29:0], 1'b0};
                     end
                  end
               end

               WDATA: begin
                  if (sclk_rise) begin
                     shift_reg <= {shift_reg[29:0], mosi_s};
                     if (bit_cnt_reg == DATA_LAST) begin
                        bit_cnt_reg <= '0;
                        state_reg   <= IGNORE;
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                     end
                  end
               end

               IGNORE: begin
                  spi_miso_oe <= 1'b0;
                  spi_miso    <= 1'b0;
               end

               default: begin
                  state_reg <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_spi_mem_responder.sv
// tb_spi_mem_responder
//   Self-checking bench: acts as a mode-0 SPI master, keeps a word-array
//   model of the responder memory and compares serial read data, output
//   enables, strobes and backdoor contents against it.
module tb_spi_mem_responder;

   localparam int DEPTH = 256;
   localparam int AW    = 8;
   localparam int HALF  = 8;   // CLK cycles per spi_clk half period

   logic          CLK = 1'b0;
   logic          reset_n = 1'b0;
   logic          spi_clk = 1'b0;
   logic          spi_mosi = 1'b0;
   logic          spi_cs_n = 1'b1;
   logic          spi_miso;
   logic          spi_miso_oe;
   logic          busy;
   logic          wr_strobe;
   logic          rd_strobe;
   logic          bd_we = 1'b0;
   logic [AW-1:0] bd_addr = '0;
   logic [31:0]   bd_wdata = '0;
   logic [31:0]   bd_rdata;

   int n_checks = 0;
   int n_pass   = 0;
   int wr_cnt   = 0;
   int rd_cnt   = 0;

   logic [31:0] model [DEPTH];

   spi_mem_responder #(.DEPTH(DEPTH), .AW(AW)) dut (
      .CLK         (CLK),
      .reset_n     (reset_n),
      .spi_clk     (spi_clk),
      .spi_mosi    (spi_mosi),
      .spi_cs_n    (spi_cs_n),
      .spi_miso    (spi_miso),
      .spi_miso_oe (spi_miso_oe),
      .busy        (busy),
      .wr_strobe   (wr_strobe),
      .rd_strobe   (rd_strobe),
      .bd_we       (bd_we),
      .bd_addr     (bd_addr),
      .bd_wdata    (bd_wdata),
      .bd_rdata    (bd_rdata)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (wr_strobe) wr_cnt++;
      if (rd_strobe) rd_cnt++;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation time limit reached, observed=running required=finished");
      $fatal(1, "watchdog");
   end

   // Word index selected by a byte address: addr[AW+1:2], modulo DEPTH.
   function automatic int idx_of(input logic [23:0] a);
      return int'(a[AW+1:2]);
   endfunction

   task automatic bd_write(input int idx, input logic [31:0] d);
      @(negedge CLK);
      bd_we    = 1'b1;
      bd_addr  = AW'(idx);
      bd_wdata = d;
      @(negedge CLK);
      bd_we = 1'b0;
      model[idx] = d;
   endtask

   task automatic bd_read(input int idx, output logic [31:0] d);
      @(negedge CLK);
      bd_addr = AW'(idx);
      @(negedge CLK);
      d = bd_rdata;
   endtask

   // One SPI frame of nbits clocks. rx/oe_v hold miso/oe sampled at each
   // of the first 64 rising edges (bit i at position 63-i); tail counts
   // miso ones beyond bit 64. rst_at >= 0 asserts reset before that rise.
   task automatic spi_frame(input logic [63:0] txv, input int nbits, input int gap,
                            input int rst_at, output logic [63:0] rx,
                            output logic [63:0] oe_v, output int tail,
                            output logic [2:0] rst_obs, output logic busy_mid);
      rx = '0; oe_v = '0; tail = 0; rst_obs = 3'b111; busy_mid = 1'b0;
      @(negedge CLK);
      spi_cs_n = 1'b0;
      repeat (4) @(negedge CLK);
      for (int i = 0; i < nbits; i++) begin
         if (i < 64) spi_mosi = txv[63-i];
         else        spi_mosi = 1'($urandom_range(0, 1));
         repeat (HALF) @(negedge CLK);
         if (i < 64) begin
            rx[63-i]   = spi_miso;
            oe_v[63-i] = spi_miso_oe;
         end else if (spi_miso) begin
            tail++;
         end
         if (i == 1) busy_mid = busy;
         if (i == rst_at) begin
            reset_n = 1'b0;
            #1;
            rst_obs = {spi_miso, spi_miso_oe, busy};
            spi_clk  = 1'b0;
            spi_cs_n = 1'b1;
            spi_mosi = 1'b0;
            repeat (3) @(negedge CLK);
            reset_n = 1'b1;
            repeat (gap) @(negedge CLK);
            $display("frame cmd=%h addr=%h nbits=%0d reset at bit %0d", txv[63:56], txv[55:32], nbits, i);
            return;
         end
         spi_clk = 1'b1;
         repeat (HALF) @(negedge CLK);
         spi_clk = 1'b0;
      end
      repeat (HALF) @(negedge CLK);
      spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
      repeat (gap) @(negedge CLK);
      $display("frame cmd=%h addr=%h data=%h nbits=%0d rx=%h oe=%h", txv[63:56], txv[55:32], txv[31:0], nbits, rx, oe_v);
   endtask

   // ------------------------------------------------------------------
   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge CLK);
      n_checks++; if (spi_miso !== 1'b0) $display("FAIL reset_miso: got %b want 0", spi_miso); else n_pass++;
      n_checks++; if (spi_miso_oe !== 1'b0) $display("FAIL reset_oe: got %b want 0", spi_miso_oe); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_checks++; if (wr_strobe !== 1'b0) $display("FAIL reset_wr_strobe: got %b want 0", wr_strobe); else n_pass++;
      n_checks++; if (rd_strobe !== 1'b0) $display("FAIL reset_rd_strobe: got %b want 0", rd_strobe); else n_pass++;
      n_checks++; if (bd_rdata !== 32'h0) $display("FAIL reset_bd_rdata: got %h want 0", bd_rdata); else n_pass++;
      reset_n = 1'b1;
      repeat (2) @(negedge CLK);
      for (int i = 0; i < DEPTH; i++) bd_write(i, $urandom);
      $display("reset done, array preloaded");
   endtask

   task automatic test_read();
      logic [63:0] rx, oe_v; int tail; logic [2:0] ro; logic bm;
      bd_write(5, 32'hDEADBEEF);
      wr_cnt = 0; rd_cnt = 0;
      spi_frame({8'h03, 24'h000014, 32'h0}, 64, 6, -1, rx, oe_v, tail, ro, bm);
      n_checks++; if (rx[31:0] !== 32'hDEADBEEF) $display("FAIL read_data: got %h want deadbeef", rx[31:0]); else n_pass++;
      n_checks++; if (rd_cnt !== 1) $display("FAIL read_rd_strobe: got %0d want 1", rd_cnt); else n_pass++;
      n_checks++; if (wr_cnt !== 0) $display("FAIL read_wr_strobe: got %0d want 0", wr_cnt); else n_pass++;
      n_checks++; if (oe_v !== 64'h0000_0000_FFFF_FFFF) $display("FAIL read_oe: got %h want 00000000ffffffff", oe_v); else n_pass++;
      n_checks++; if (bm !== 1'b1) $display("FAIL read_busy_mid: got %b want 1", bm); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL read_busy_end: got %b want 0", busy); else n_pass++;
   endtask

   task automatic test_write();
      logic [63:0] rx, oe_v; int tail; logic [2:0] ro; logic bm; logic [31:0] d;
      wr_cnt = 0; rd_cnt = 0;
      spi_frame({8'h02, 24'h000020, 32'h12345678}, 64, 6, -1, rx, oe_v, tail, ro, bm);
      model[8] = 32'h12345678;
      n_checks++; if (wr_cnt !== 1) $display("FAIL write_wr_strobe: got %0d want 1", wr_cnt); else n_pass++;
      n_checks++; if (rd_cnt !== 0) $display("FAIL write_rd_strobe: got %0d want 0", rd_cnt); else n_pass++;
      n_checks++; if (oe_v !== 64'h0) $display("FAIL write_oe: got %h want 0", oe_v); else n_pass++;
      bd_read(8, d);
      n_checks++; if (d !== 32'h12345678) $display("FAIL write_bd_read: got %h want 12345678", d); else n_pass++;
   endtask

   task automatic test_abort();
      logic [63:0] rx, oe_v; int tail; logic [2:0] ro; logic bm; logic [31:0] d;
      bd_write(12, 32'hA5A5A5A5);
      wr_cnt = 0; rd_cnt = 0;
      spi_frame({8'h02, 24'h000030, 32'($urandom)}, 52, 6, -1, rx, oe_v, tail, ro, bm);
      n_checks++; if (wr_cnt !== 0) $display("FAIL abort_wr_strobe: got %0d want 0", wr_cnt); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
      bd_read(12, d);
      n_checks++; if (d !== 32'hA5A5A5A5) $display("FAIL abort_word: got %h want a5a5a5a5", d); else n_pass++;
   endtask

   task automatic test_ignore();
      logic [63:0] rx, oe_v; int tail; logic [2:0] ro; logic bm;
      wr_cnt = 0; rd_cnt = 0;
      spi_frame({8'h9F, 56'({$urandom, $urandom})}, 64, 6, -1, rx, oe_v, tail, ro, bm);
      n_checks++; if (oe_v !== 64'h0) $display("FAIL ignore_oe: got %h want 0", oe_v); else n_pass++;
      n_checks++; if (rx !== 64'h0) $display("FAIL ignore_miso: got %h want 0", rx); else n_pass++;
      n_checks++; if (wr_cnt + rd_cnt !== 0) $display("FAIL ignore_strobes: got %0d want 0", wr_cnt + rd_cnt); else n_pass++;
      spi_frame({8'h03, 24'h000014, 32'h0}, 64, 6, -1, rx, oe_v, tail, ro, bm);
      n_checks++; if (rx[31:0] !== model[5]) $display("FAIL ignore_next_read: got %h want %h", rx[31:0], model[5]); else n_pass++;
   endtask

   task automatic test_wrap();
      logic [63:0] rx, oe_v; int tail; logic [2:0] ro; logic bm; logic [31:0] d, r;
      d = $urandom;
      spi_frame({8'h02, 24'h000400, d}, 64, 6, -1, rx, oe_v, tail, ro, bm);
      model[0] = d;
      bd_read(0, r);
      n_checks++; if (r !== d) $display("FAIL wrap_word0: got %h want %h", r, d); else n_pass++;
   endtask

   task automatic test_reset_mid_read();
      logic [63:0] rx, oe_v; int tail; logic [2:0] ro; logic bm; int idx; logic [31:0] r;
      idx = $urandom_range(0, DEPTH - 1);
      spi_frame({8'h03, 24'(idx * 4), 32'h0}, 64, 6, 40, rx, oe_v, tail, ro, bm);
      n_checks++; if (ro !== 3'b000) $display("FAIL rst_mid_outputs: got miso/oe/busy=%b want 000", ro); else n_pass++;
      spi_frame({8'h03, 24'(idx * 4), 32'h0}, 64, 6, -1, rx, oe_v, tail, ro, bm);
      n_checks++; if (rx[31:0] !== model[idx]) $display("FAIL rst_mid_reread: got %h want %h", rx[31:0], model[idx]); else n_pass++;
      bd_read(idx, r);
      n_checks++; if (r !== model[idx]) $display("FAIL rst_mid_bd: got %h want %h", r, model[idx]); else n_pass++;
   endtask

   task automatic test_random();
      logic [63:0] rx, oe_v, oe_exp; int tail; logic [2:0] ro; logic bm;
      logic [7:0] cmd; logic [23:0] addr; logic [31:0] d, r;
      int nb, idx, exp_wr, exp_rd;
      int nb_tab [5] = '{64, 64, 70, 44, 20};
      logic [7:0] bad_tab [4] = '{8'h9F, 8'h00, 8'hFF, 8'h0B};
      for (int t = 0; t < 16; t++) begin
         case ($urandom_range(0, 3))
            0, 1:    cmd = 8'h03;
            2:       cmd = 8'h02;
            default: cmd = bad_tab[$urandom_range(0, 3)];
         endcase
         addr = 24'($urandom);
         d    = $urandom;
         nb   = nb_tab[$urandom_range(0, 4)];
         idx  = idx_of(addr);
         exp_wr = (cmd == 8'h02 && nb >= 64) ? 1 : 0;
         exp_rd = (cmd == 8'h03 && nb >= 32) ? 1 : 0;
         oe_exp = '0;
         for (int i = 0; i < 64 && i < nb; i++) oe_exp[63-i] = (cmd == 8'h03 && i >= 32);
         wr_cnt = 0; rd_cnt = 0;
         spi_frame({cmd, addr, d}, nb, $urandom_range(4, 8), -1, rx, oe_v, tail, ro, bm);
         n_checks++; if (wr_cnt !== exp_wr) $display("FAIL rand%0d_wr: got %0d want %0d", t, wr_cnt, exp_wr); else n_pass++;
         n_checks++; if (rd_cnt !== exp_rd) $display("FAIL rand%0d_rd: got %0d want %0d", t, rd_cnt, exp_rd); else n_pass++;
         n_checks++; if (oe_v !== oe_exp) $display("FAIL rand%0d_oe: got %h want %h", t, oe_v, oe_exp); else n_pass++;
         n_checks++; if (tail !== 0) $display("FAIL rand%0d_tail: got %0d ones want 0", t, tail); else n_pass++;
         if (cmd == 8'h03 && nb >= 64) begin
            n_checks++; if (rx[31:0] !== model[idx]) $display("FAIL rand%0d_rdata: got %h want %h", t, rx[31:0], model[idx]); else n_pass++;
         end
         if (exp_wr == 1) model[idx] = d;
         bd_read(idx, r);
         n_checks++; if (r !== model[idx]) $display("FAIL rand%0d_word: got %h want %h", t, r, model[idx]); else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] rx, oe_v; int tail; logic [2:0] ro; logic bm;
      logic [23:0] addr; logic [31:0] d; int idx;
      addr = 24'($urandom);
      d    = $urandom;
      idx  = idx_of(addr);
      wr_cnt = 0; rd_cnt = 0;
      spi_frame({8'h02, addr, d}, 64, 4, -1, rx, oe_v, tail, ro, bm);
      model[idx] = d;
      spi_frame({8'h03, addr, 32'h0}, 64, 4, -1, rx, oe_v, tail, ro, bm);
      n_checks++; if (rx[31:0] !== d) $display("FAIL b2b_rdata: got %h want %h", rx[31:0], d); else n_pass++;
      n_checks++; if (wr_cnt !== 1 || rd_cnt !== 1) $display("FAIL b2b_strobes: got wr=%0d rd=%0d want 1/1", wr_cnt, rd_cnt); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_abort();
      test_ignore();
      test_wrap();
      test_reset_mid_read();
      test_random();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
